// File: rtl/core_pkg.sv
// core_pkg: shared result-select encoding and register constants for the core
package core_pkg;
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_RSV = 2'b11
    } result_src_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/mem_wb_if.sv
// mem_wb_if: M-stage inputs, W-stage controls and writeback outputs of the MEM/WB stage
interface mem_wb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 64
);
    logic                  ValidM;
    logic                  StallW;
    logic                  FlushW;
    logic                  RegWriteM;
    logic [1:0]            ResultSrcM;
    logic [DATA_WIDTH-1:0] ALUResultMW;
    logic [DATA_WIDTH-1:0] ReadPartDataM;
    logic [DATA_WIDTH-1:0] PCPlus4M;
    logic [4:0]            RdM;
    logic [DATA_WIDTH-1:0] ResultW;
    logic [4:0]            RdW;
    logic                  RegWriteW;
    logic                  ValidW;
    logic [CNT_WIDTH-1:0]  InstRetW;
    modport master (
        output ValidM, StallW, FlushW, RegWriteM, ResultSrcM, ALUResultMW, ReadPartDataM, PCPlus4M, RdM,
        input  ResultW, RdW, RegWriteW, ValidW, InstRetW
    );
    modport slave (
        input  ValidM, StallW, FlushW, RegWriteM, ResultSrcM, ALUResultMW, ReadPartDataM, PCPlus4M, RdM,
        output ResultW, RdW, RegWriteW, ValidW, InstRetW
    );
endinterface

// File: rtl/mem_wb_stage_retire_counter.sv
// retire_counter: wrapping count of instructions leaving the writeback stage
module retire_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);
    // count one per retiring instruction, wrapping silently at all-ones
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (inc) count <= count + CNT_WIDTH'(1);
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with writeback result select and retire count
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 64
) (
    input logic   clk,
    input logic   rst_n,
    mem_wb_if.slave bus
);
    logic                  valid_w;
    logic                  regwrite_r;
    logic [4:0]            rd_w;
    result_src_t           src_w;
    logic [DATA_WIDTH-1:0] alu_w;
    logic [DATA_WIDTH-1:0] read_w;
    logic [DATA_WIDTH-1:0] pc4_w;
    logic [DATA_WIDTH-1:0] result;
    logic [CNT_WIDTH-1:0]  inst_ret;
    // W register: flush makes a bubble (data held), stall holds all, otherwise load from M
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid_w    <= 1'b0;
            regwrite_r <= 1'b0;
            rd_w       <= REG_ZERO;
            src_w      <= RES_ALU;
            alu_w      <= '0;
            read_w     <= '0;
            pc4_w      <= '0;
        end else if (bus.FlushW) begin
            valid_w    <= 1'b0;
            regwrite_r <= 1'b0;
        end else if (!bus.StallW) begin
            valid_w    <= bus.ValidM;
            regwrite_r <= bus.RegWriteM & bus.ValidM;
            rd_w       <= bus.RdM;
            src_w      <= result_src_t'(bus.ResultSrcM);
            alu_w      <= bus.ALUResultMW;
            read_w     <= bus.ReadPartDataM;
            pc4_w      <= bus.PCPlus4M;
        end
    // writeback value selected purely from W registers; reserved encoding yields zero
    always_comb
        result = src_w == RES_ALU ? alu_w :
                 src_w == RES_MEM ? read_w :
                 src_w == RES_PC4 ? pc4_w : '0;
    retire_counter #(.CNT_WIDTH(CNT_WIDTH)) u_retire (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (valid_w & ~bus.StallW & ~bus.FlushW),
        .count(inst_ret)
    );
    assign bus.ResultW   = result;
    assign bus.RdW       = rd_w;
    assign bus.ValidW    = valid_w;
    assign bus.RegWriteW = regwrite_r & valid_w & (rd_w != REG_ZERO);
    assign bus.InstRetW  = inst_ret;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench driving directed M-stage vectors into two stage instances
module tb_mem_wb_stage;
    import core_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic        v;
        logic        rw;
        logic        dc;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [63:0] cnt;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;
    logic [63:0] exp_cnt = '0;
    logic prev_ev = 1'b0;

    always #5 clk = ~clk;

    mem_wb_if #(.DATA_WIDTH(32), .CNT_WIDTH(64)) bus ();
    mem_wb_if #(.DATA_WIDTH(32), .CNT_WIDTH(4))  bus4 ();

    assign bus4.ValidM        = bus.ValidM;
    assign bus4.StallW        = bus.StallW;
    assign bus4.FlushW        = bus.FlushW;
    assign bus4.RegWriteM     = bus.RegWriteM;
    assign bus4.ResultSrcM    = bus.ResultSrcM;
    assign bus4.ALUResultMW   = bus.ALUResultMW;
    assign bus4.ReadPartDataM = bus.ReadPartDataM;
    assign bus4.PCPlus4M      = bus.PCPlus4M;
    assign bus4.RdM           = bus.RdM;

    mem_wb_stage #(.DATA_WIDTH(32), .CNT_WIDTH(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    mem_wb_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic vm, input logic rw, input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc4, input logic [4:0] rd,
                         input logic st, input logic fl);
        bus.ValidM        = vm;
        bus.RegWriteM     = rw;
        bus.ResultSrcM    = src;
        bus.ALUResultMW   = alu;
        bus.ReadPartDataM = mem;
        bus.PCPlus4M      = pc4;
        bus.RdM           = rd;
        bus.StallW        = st;
        bus.FlushW        = fl;
    endtask

    task automatic step(input logic vm, input logic rw, input logic [1:0] src, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] pc4, input logic [4:0] rd,
                        input logic st, input logic fl,
                        input logic ev, input logic erw, input logic dc, input logic [4:0] erd,
                        input logic [31:0] eres);
        exp_t e;
        @(negedge clk);
        drive(vm, rw, src, alu, mem, pc4, rd, st, fl);
        if (prev_ev && !st && !fl) exp_cnt++;
        prev_ev = ev;
        e.v = ev; e.rw = erw; e.dc = dc; e.rd = erd; e.res = eres; e.cnt = exp_cnt;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.ValidW), 64'(0));
        chk({tag, "_regwrite"}, 64'(bus.RegWriteW), 64'(0));
        chk({tag, "_rd"}, 64'(bus.RdW), 64'(0));
        chk({tag, "_result"}, 64'(bus.ResultW), 64'(0));
        chk({tag, "_instret"}, bus.InstRetW, 64'(0));
        chk({tag, "_instret4"}, 64'(bus4.InstRetW), 64'(0));
    endtask

    // monitor: compare W outputs against the queued expectation after every edge
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("valid", 64'(bus.ValidW), 64'(mon_e.v));
            chk("regwrite", 64'(bus.RegWriteW), 64'(mon_e.rw));
            if (!mon_e.dc) begin
                chk("rd", 64'(bus.RdW), 64'(mon_e.rd));
                chk("result", 64'(bus.ResultW), 64'(mon_e.res));
            end
            chk("instret", bus.InstRetW, mon_e.cnt);
            chk("instret4", 64'(bus4.InstRetW), 64'(mon_e.cnt[3:0]));
        end
    end

    initial begin
        drive(1'b1, 1'b1, RES_ALU, 32'hDEAD_BEEF, 32'h1, 32'h2, 5'd7, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk_zero("reset");
        drive(1'b0, 1'b0, RES_ALU, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        //    vm rw src      alu            mem            pc4            rd    st fl   ev erw dc erd   eres
        step(1, 1, RES_ALU, 32'h1234_5678, 32'h0,         32'h0,         5'd5, 0, 0,  1, 1, 0, 5'd5, 32'h1234_5678);
        step(1, 1, RES_MEM, 32'h0,         32'hFFFF_FF80, 32'h0,         5'd6, 0, 0,  1, 1, 0, 5'd6, 32'hFFFF_FF80);
        step(1, 1, RES_PC4, 32'h0,         32'h0,         32'h0000_0104, 5'd7, 0, 0,  1, 1, 0, 5'd7, 32'h0000_0104);
        step(1, 1, RES_RSV, 32'hAAAA,      32'hBBBB,      32'hCCCC,      5'd8, 0, 0,  1, 1, 0, 5'd8, 32'h0);
        step(1, 1, RES_ALU, 32'h11,        32'h0,         32'h0,         5'd0, 0, 0,  1, 0, 0, 5'd0, 32'h11);
        step(0, 1, RES_ALU, 32'h22,        32'h0,         32'h0,         5'd9, 0, 0,  0, 0, 0, 5'd9, 32'h22);
        step(0, 1, RES_ALU, 32'h33,        32'h0,         32'h0,        5'd10, 0, 0,  0, 0, 0, 5'd10, 32'h33);
        step(1, 1, RES_ALU, 32'hA0A0,      32'h0,         32'h0,         5'd3, 0, 0,  1, 1, 0, 5'd3, 32'hA0A0);
        step(1, 1, RES_ALU, 32'h5151,      32'h0,         32'h0,        5'd12, 1, 0,  1, 1, 0, 5'd3, 32'hA0A0);
        step(1, 1, RES_MEM, 32'h0,         32'h5252,      32'h0,        5'd13, 1, 0,  1, 1, 0, 5'd3, 32'hA0A0);
        step(0, 1, RES_PC4, 32'h0,         32'h0,         32'h5353,     5'd14, 1, 0,  1, 1, 0, 5'd3, 32'hA0A0);
        step(1, 1, RES_MEM, 32'h0,         32'hB0B0,      32'h0,         5'd4, 0, 0,  1, 1, 0, 5'd4, 32'hB0B0);
        step(1, 1, RES_ALU, 32'h9999,      32'h0,         32'h0,        5'd15, 1, 1,  0, 0, 1, 5'd0, 32'h0);
        step(1, 1, RES_ALU, 32'hC0C0,      32'h0,         32'h0,         5'd2, 0, 0,  1, 1, 0, 5'd2, 32'hC0C0);
        @(negedge clk);
        chk("pre_async_valid", 64'(bus.ValidW), 64'(1));
        #2 rst_n = 1'b0;
        #1 chk_zero("async");
        @(negedge clk);
        drive(1'b0, 1'b0, RES_ALU, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        exp_cnt = '0;
        prev_ev = 1'b0;
        for (int i = 1; i <= 10; i++)
            step(1, 1, RES_ALU, 32'(i), 32'h0, 32'h0, 5'(i), 0, 0, 1, 1, 0, 5'(i), 32'(i));
        step(0, 1, RES_ALU, 32'h0, 32'h0, 32'h0, 5'd0, 0, 1, 0, 0, 1, 5'd0, 32'h0);
        step(0, 1, RES_ALU, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 32'h0);
        @(negedge clk);
        chk("count_nine", bus.InstRetW, 64'd9);
        for (int i = 1; i <= 8; i++)
            step(1, 1, RES_PC4, 32'h0, 32'h0, 32'(4 * i), 5'(i + 16), 0, 0, 1, 1, 0, 5'(i + 16), 32'(4 * i));
        step(0, 0, RES_ALU, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 32'h0);
        @(negedge clk);
        chk("count_17", bus.InstRetW, 64'd17);
        chk("count_wrap4", 64'(bus4.InstRetW), 64'd1);
        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback-result selection for the 5-stage RISC-V core.
- Consumes the memory-stage outputs: load-aligned read data, ALU result, PC+4, Rd, RegWrite and ResultSrc.
- Produces the register-file write port (ResultW, RdW, RegWriteW), which is also the W-stage forwarding source for the hazard unit.
- Adds stall/flush control, a valid bit for bubbles, and a retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, width of the data path.
- CNT_WIDTH, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ValidM  in  1  M stage holds a real instruction, not a bubble
- StallW  in  1  hold the W register contents
- FlushW  in  1  synchronous bubble insert into W
- RegWriteM  in  1  register-file write enable from M
- ResultSrcM  in  2  result select from M
- ALUResultMW  in  DATA_WIDTH  ALU result passed through M
- ReadPartDataM  in  DATA_WIDTH  load data, already sign/zero extended
- PCPlus4M  in  DATA_WIDTH  PC+4 from M
- RdM  in  5  destination register from M
- ResultW  out  DATA_WIDTH  writeback value
- RdW  out  5  writeback destination
- RegWriteW  out  1  register-file write enable
- ValidW  out  1  W stage holds a real instruction
- InstRetW  out  CNT_WIDTH  count of retired instructions

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: all W registers clear.
  - ValidW=0, RegWriteW=0, RdW=0, ResultW=0, InstRetW=0.
  - Internal ResultSrcW=2'b00, ALUResultW=0, ReadDataW=0, PCPlus4W=0.
- Latency: 1 cycle M->W. Inputs sampled at rising clk appear on the W outputs after that edge.
- Per-edge priority, highest first:
  - FlushW=1: ValidW<=0 and RegWrite register<=0. Data fields may load or hold; they are don't-care but must not be X.
  - Else StallW=1: every W register holds.
  - Else: load all fields from M. ValidW<=ValidM. RegWrite register<=RegWriteM & ValidM.
  - FlushW with StallW both high: flush wins.
- Result mux, combinational from W registers:
  - 00 -> ALUResultW
  - 01 -> ReadDataW
  - 10 -> PCPlus4W
  - 11 -> 0 (reserved)
- RegWriteW = RegWrite register & ValidW & (RdW != 0). Writes to x0 are suppressed at the output.
- ResultW is driven whenever ValidW=0, but is meaningless in that case.
- Retire counter:
  - Increments by 1 on each rising edge where ValidW=1 and StallW=0 and FlushW=0, i.e. the cycle the instruction leaves W.
  - A stalled instruction is counted once, on release.
  - An instruction flushed while in W is not counted.
  - An instruction whose RegWrite is 0 (stores, branches) is still counted.
  - Wraps modulo 2^CNT_WIDTH, all-ones -> 0, with no flag.
- Reset mid-operation: asynchronous clear of all of the above regardless of stall/flush. The first valid instruction after rst_n deasserts reaches W after one edge.
- No combinational path from any M input to any W output.

Decomposition:
- Package core_pkg:
  - result_src_t enum: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_RSV=2'b11.
  - Constant REG_ZERO=5'd0.
- Sub-module retire_counter, parameterised by CNT_WIDTH.
  - Inputs: clk, rst_n, inc.
  - Output: count.
  - The stage drives inc = ValidW & ~StallW & ~FlushW.
- Result mux stays inline.

Test Plan:
- Reset: hold rst_n=0 while driving M inputs with values -> all outputs 0. Release; next edge captures ValidM=1, RES_ALU, ALUResultMW=32'h1234_5678, RdM=5 -> ResultW=32'h1234_5678, RdW=5, RegWriteW=1.
- Mux: three consecutive instructions -> ResultW in successive cycles is 32'hFFFF_FF80, then 32'h0000_0104, then 0.
  - RES_MEM with ReadPartDataM=32'hFFFF_FF80.
  - RES_PC4 with PCPlus4M=32'h0000_0104.
  - RES_RSV.
- x0 and bubble:
  - RdM=0 with RegWriteM=1 -> RegWriteW=0.
  - ValidM=0 with RegWriteM=1 -> ValidW=0, RegWriteW=0, InstRetW unchanged.
- Stall/flush:
  - Load instruction A, assert StallW for 3 cycles while M changes -> W outputs stay A and InstRetW rises by 1 only after release.
  - FlushW with StallW both high -> ValidW=0, RegWriteW=0 next edge.
- Counter: stream 10 valid instructions, one of them flushed in W -> InstRetW=9. With CNT_WIDTH=4 and 17 retirements -> InstRetW=1 (wrap).
- Async reset mid-stream: pulse rst_n low between edges while ValidW=1 -> outputs clear immediately, before the next clk edge.
